// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2 restoring divider (DIV/DIVU/REM/REMU) with start/busy/done handshake
// Ports: clk; rst (sync, active-low); start/flush requests; div_opcode 00 DIV 01 DIVU 10 REM 11 REMU;
//        operand1 dividend, operand2 divisor; busy, doneD (one-cycle pulse), result_divide (held).
// Optional DIV_REUSE_EN: remembers the last full-path operands and both results so a matching
//        DIV<->REM / DIVU<->REMU request completes without iterating.
module iter_divider #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       div_opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             doneD,
  output logic [WIDTH-1:0] result_divide
);
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic op_rem, neg_q, neg_r, spec;
  logic [WIDTH-1:0] rem, quo, dvs, spec_res;
  logic sgn, a_neg, b_neg, dz, ovf, hit;
  logic [WIDTH-1:0] a_mag, b_mag, hit_res, res_q, res_r, pre_res;
  logic [WIDTH:0] sh, diff;
  assign busy = state != IDLE;
  always_comb begin
    sgn = ~div_opcode[0];
    a_neg = sgn & operand1[WIDTH-1];
    b_neg = sgn & operand2[WIDTH-1];
    a_mag = a_neg ? -operand1 : operand1;
    b_mag = b_neg ? -operand2 : operand2;
    dz = operand2 == '0;
    ovf = sgn && operand1 == {1'b1, {(WIDTH-1){1'b0}}} && operand2 == '1;
    pre_res = dz ? (div_opcode[1] ? operand1 : '1) : ovf ? (div_opcode[1] ? '0 : operand1) : hit_res;
    sh = {rem, quo[WIDTH-1]};
    diff = sh - {1'b0, dvs};
    res_q = neg_q ? -quo : quo;
    res_r = neg_r ? -rem : rem;
  end
`ifdef DIV_REUSE_EN
  logic tag_v, tag_s;
  logic [WIDTH-1:0] tag_a, tag_b, tag_q, tag_r;
  assign hit = tag_v && tag_s == sgn && tag_a == operand1 && tag_b == operand2;
  assign hit_res = div_opcode[1] ? tag_r : tag_q;
  // Tag operands are captured at a full-path start and only become valid once FIXUP completes.
  always_ff @(posedge clk)
    if (!rst || flush) tag_v <= 1'b0;
    else if (state == IDLE && start && !(dz || ovf || hit)) begin
      tag_v <= 1'b0;
      tag_s <= sgn;
      tag_a <= operand1;
      tag_b <= operand2;
    end else if (state == FIXUP && !spec) begin
      tag_v <= 1'b1;
      tag_q <= res_q;
      tag_r <= res_r;
    end
`else
  assign hit = 1'b0;
  assign hit_res = '0;
`endif
  // Short-cut results still pass through FIXUP so every completion is registered the same way.
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      doneD <= 1'b0;
      result_divide <= '0;
      cnt <= '0;
    end else if (flush) begin
      state <= IDLE;
      doneD <= 1'b0;
    end else begin
      doneD <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_rem <= div_opcode[1];
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          rem <= '0;
          quo <= a_mag;
          dvs <= b_mag;
          spec <= dz | ovf | hit;
          spec_res <= pre_res;
          cnt <= CNT_W'(WIDTH);
          state <= (dz | ovf | hit) ? FIXUP : CALC;
        end
        CALC: begin
          rem <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIXUP;
        end
        FIXUP: begin
          result_divide <= spec ? spec_res : op_rem ? res_r : res_q;
          doneD <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: randomized and directed checks of iter_divider against an arithmetic reference
module tb_iter_divider;
  logic clk = 0, rst = 0, start = 0, flush = 0, start8 = 0;
  logic [1:0] div_opcode = 0, op8 = 0;
  logic [31:0] operand1 = 0, operand2 = 0, result_divide;
  logic [7:0] a8 = 0, b8 = 0, res8;
  logic busy, doneD, busy8, done8;
  int n_tests = 0, n_fail = 0;
  bit tv = 0, ts = 0;
  logic [31:0] ta = 0, tb = 0;
`ifdef DIV_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif
  localparam logic [31:0] MIN = 32'h8000_0000;

  iter_divider #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .start(start), .flush(flush),
    .div_opcode(div_opcode), .operand1(operand1), .operand2(operand2),
    .busy(busy), .doneD(doneD), .result_divide(result_divide));
  iter_divider #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .flush(flush),
    .div_opcode(op8), .operand1(a8), .operand2(b8),
    .busy(busy8), .doneD(done8), .result_divide(res8));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == MIN && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
      return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return op[1] ? a % b : a / b;
  endfunction

  task automatic wait_done(input int c0, output int cyc, output int busy_bad);
    cyc = c0;
    busy_bad = 0;
    while (!doneD && cyc < 60) begin
      if (!busy) busy_bad++;
      @(posedge clk); #1;
      cyc++;
    end
    if (!busy) busy_bad++;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit poke_done);
    int cyc, busy_bad, exp_lat;
    bit special, hit;
    logic [31:0] exp_res;
    special = b == 0 || (!op[0] && a == MIN && b == 32'hFFFF_FFFF);
    hit = REUSE && tv && ts == !op[0] && ta == a && tb == b;
    exp_lat = (special || hit) ? 2 : 34;
    exp_res = ref_op(op, a, b);
    div_opcode = op; operand1 = a; operand2 = b; start = 1;
    @(posedge clk); #1;
    start = 0; operand1 = $urandom; operand2 = $urandom; div_opcode = 2'($urandom_range(3));
    wait_done(1, cyc, busy_bad);
    chk({tag, " done"}, 32'(doneD), 1);
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " result"}, result_divide, exp_res);
    chk({tag, " busy"}, busy_bad, 0);
    if (!special && !hit) begin tv = 1; ts = !op[0]; ta = a; tb = b; end
    if (poke_done) begin start = 1; operand1 = 32'd9; operand2 = 32'd4; end
    @(posedge clk); #1;
    start = 0;
    chk({tag, " pulse"}, 32'(doneD), 0);
    chk({tag, " idle"}, 32'(busy), 0);
    chk({tag, " held"}, result_divide, exp_res);
  endtask

  task automatic run8(input string tag, input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp_res, input int exp_lat);
    int cyc;
    op8 = op; a8 = a; b8 = b; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    cyc = 1;
    while (!done8 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " result"}, 32'(res8), 32'(exp_res));
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, busy_bad, rises;
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 0);
    chk("reset doneD", 32'(doneD), 0);
    chk("reset result", result_divide, 0);
    rst = 1;
    @(posedge clk); #1;

    run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div -7/2 literal", result_divide, 32'hFFFF_FFFD);
    run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    chk("rem -7/2 literal", result_divide, 32'hFFFF_FFFF);
    run_op("divu ffffffff/16", 2'b01, 32'hFFFF_FFFF, 32'h10, 0);
    chk("divu literal", result_divide, 32'h0FFF_FFFF);
    run_op("remu ffffffff/16", 2'b11, 32'hFFFF_FFFF, 32'h10, 1);
    chk("remu literal", result_divide, 32'hF);
    run_op("div 5/0", 2'b00, 32'd5, 32'd0, 0);
    chk("div0 literal", result_divide, 32'hFFFF_FFFF);
    run_op("remu 5/0", 2'b11, 32'd5, 32'd0, 0);
    chk("remu0 literal", result_divide, 32'd5);
    run_op("div ovf", 2'b00, MIN, 32'hFFFF_FFFF, 0);
    chk("div ovf literal", result_divide, MIN);
    run_op("rem ovf", 2'b10, MIN, 32'hFFFF_FFFF, 0);
    chk("rem ovf literal", result_divide, 32'h0);

    div_opcode = 2'b01; operand1 = 32'd1000; operand2 = 32'd3; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (9) @(posedge clk);
    #1;
    div_opcode = 2'b00; operand1 = 32'd77; operand2 = 32'd5; start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done(11, cyc, busy_bad);
    chk("repulse latency", cyc, 34);
    chk("repulse result", result_divide, 32'd333);
    tv = 1; ts = 0; ta = 32'd1000; tb = 32'd3;
    @(posedge clk); #1;

    div_opcode = 2'b00; operand1 = 32'hFFFF_FF9C; operand2 = 32'd9; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (14) @(posedge clk);
    #1;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    tv = 0;
    chk("flush busy", 32'(busy), 0);
    chk("flush doneD", 32'(doneD), 0);
    chk("flush result", result_divide, 32'd333);
    rises = 0;
    repeat (40) begin @(posedge clk); #1; if (doneD) rises++; end
    chk("flush no done", rises, 0);

    flush = 1; start = 1; div_opcode = 2'b01; operand1 = 32'd50; operand2 = 32'd5;
    @(posedge clk); #1;
    flush = 0; start = 0;
    chk("flush+start busy", 32'(busy), 0);

    div_opcode = 2'b01; operand1 = 32'd123456; operand2 = 32'd7; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (19) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk); #1;
    tv = 0;
    chk("midrst busy", 32'(busy), 0);
    chk("midrst doneD", 32'(doneD), 0);
    chk("midrst result", result_divide, 0);
    rst = 1;
    rises = 0;
    repeat (40) begin @(posedge clk); #1; if (doneD) rises++; end
    chk("midrst no done", rises, 0);

    run_op("div 100/7", 2'b00, 32'd100, 32'd7, 0);
    chk("div 100/7 literal", result_divide, 32'd14);
    run_op("rem 100/7", 2'b10, 32'd100, 32'd7, 0);
    chk("rem 100/7 literal", result_divide, 32'd2);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    tv = 0;
    run_op("rem 100/7 after flush", 2'b10, 32'd100, 32'd7, 0);

    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(7) == 0) ? MIN : $urandom;
      case ($urandom_range(7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(15));
        default: b = $urandom >> $urandom_range(31);
      endcase
      run_op($sformatf("rnd%0d", i), 2'($urandom_range(3)), a, b, 0);
    end

    run8("w8 div -128/-1", 2'b00, 8'h80, 8'hFF, 8'h80, 2);
    run8("w8 divu 200/3", 2'b01, 8'd200, 8'd3, 8'd66, 10);
    run8("w8 rem -7/2", 2'b10, 8'hF9, 8'd2, 8'hFF, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
